// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Runs one WIDTH*NWORDS-bit addition through an external combinational
// WIDTH-bit adder, one word per cycle, least significant word first.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, cin captured on accept)
//   out_valid/out_ready   result handshake (sum, cout held while DONE)
//   add_a/add_b/add_cin   word operands and carry driven to the adder
//   add_sum/add_cout      combinational adder response, captured each RUN edge
module multiword_add_sequencer #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*NWORDS-1:0]   a,
  input  logic [WIDTH*NWORDS-1:0]   b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*NWORDS-1:0]   sum,
  output logic                      cout,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  output logic                      add_cin,
  input  logic [WIDTH-1:0]          add_sum,
  input  logic                      add_cout
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [NWORDS-1:0][WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [IW-1:0]                idx;
  logic                         carry;
  logic                         cout_reg;

  assign sum  = sum_reg;
  assign cout = cout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs are pure state decodes; the adder pins are only
  // non-zero while a word is actually being processed.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[idx];
        add_b   = b_reg[idx];
        add_cin = carry;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            idx     <= '0;
            sum_reg <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_sum;
          carry        <= add_cout;
          // Index saturates at the top word; the next accept rewinds it.
          if (idx == LAST) cout_reg <= add_cout;
          else             idx      <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
